// File: rtl/debug_cmd_pkg.sv
// Shared constants and state encoding for the debug command host.
// Optional inter-byte timeout is enabled by DEBUG_CMD_BYTE_TIMEOUT_EN.
package debug_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    localparam int unsigned BUS_CNT_W  = 8;
    localparam int unsigned BYTE_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_BUS  = 3'd4,
        ST_RSP1 = 3'd5,
        ST_RSP2 = 3'd6
    } state_e;

    function automatic logic is_frame_state(input state_e s);
        return (s == ST_ADDR) || (s == ST_DHI) || (s == ST_DLO);
    endfunction

endpackage

// File: rtl/debug_cmd_host_if.sv
// Host link (UART RX/TX bytes) and debug register bus signals of the command host.
interface debug_cmd_host_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  dbg_a;
    logic [15:0] dbg_di;
    logic        dbg_we;
    logic        dbg_rd;
    logic [15:0] dbg_do;
    logic        dbg_ready;
    logic        busy;
    logic        overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
        output tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd, busy, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
        input  tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd, busy, overrun
    );

endinterface

// File: rtl/debug_cmd_timer.sv
// Loadable saturating down-counter; expired_o is high while the count is zero.
module debug_cmd_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear beats load beats decrement; stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/debug_cmd_host.sv
// Byte-framed read/write command parser mastering the 16-bit debug register bus.
// Optional inter-byte frame timeout: define DEBUG_CMD_BYTE_TIMEOUT_EN.
module debug_cmd_host
    import debug_cmd_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT  = 255
`ifdef DEBUG_CMD_BYTE_TIMEOUT_EN
    ,
    parameter int unsigned BYTE_TIMEOUT = 65535
`endif
) (
    input logic               clk,
    input logic               rst_n,
    debug_cmd_host_if.master  host_if
);

    state_e      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic        has_lo_q, has_lo_d;
    logic [7:0]  rd_lo_q, rd_lo_d;
    logic [7:0]  dbg_a_q, dbg_a_d;
    logic [15:0] dbg_di_q, dbg_di_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, dbg_we_q, dbg_rd_q, busy_q, overrun_q;
    logic        bus_expired_s;
    logic        byte_expired_s;

    // Counts from BUS_TIMEOUT-1 down to zero across BUS; zero marks the last wait cycle.
    debug_cmd_timer #(.WIDTH(BUS_CNT_W)) u_bus_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (1'b0),
        .load_i     (state_q != ST_BUS),
        .en_i       (state_q == ST_BUS),
        .load_val_i (BUS_CNT_W'(BUS_TIMEOUT - 1)),
        .expired_o  (bus_expired_s)
    );

`ifdef DEBUG_CMD_BYTE_TIMEOUT_EN
    debug_cmd_timer #(.WIDTH(BYTE_CNT_W)) u_byte_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (1'b0),
        .load_i     (host_if.rx_valid),
        .en_i       (is_frame_state(state_q)),
        .load_val_i (BYTE_CNT_W'(BYTE_TIMEOUT - 1)),
        .expired_o  (byte_expired_s)
    );
`else
    assign byte_expired_s = 1'b0;
`endif

    // Next-state and latched frame/response fields.
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        has_lo_d  = has_lo_q;
        rd_lo_d   = rd_lo_q;
        dbg_a_d   = dbg_a_q;
        dbg_di_d  = dbg_di_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (host_if.rx_valid && ((host_if.rx_data == OP_WRITE) || (host_if.rx_data == OP_READ))) begin
                    state_d = ST_ADDR;
                    is_wr_d = (host_if.rx_data == OP_WRITE);
                end else if (host_if.rx_valid) begin
                    state_d   = ST_RSP1;
                    tx_data_d = RSP_NAK;
                    has_lo_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (host_if.rx_valid) begin
                    dbg_a_d = host_if.rx_data;
                    state_d = is_wr_q ? ST_DHI : ST_BUS;
                end else if (byte_expired_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DHI: begin
                if (host_if.rx_valid) begin
                    dbg_di_d[15:8] = host_if.rx_data;
                    state_d        = ST_DLO;
                end else if (byte_expired_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DHI;
                end
            end
            ST_DLO: begin
                if (host_if.rx_valid) begin
                    dbg_di_d[7:0] = host_if.rx_data;
                    state_d       = ST_BUS;
                end else if (byte_expired_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DLO;
                end
            end
            ST_BUS: begin
                // dbg_ready on the final count cycle still counts as completion.
                if (host_if.dbg_ready) begin
                    state_d   = ST_RSP1;
                    has_lo_d  = !is_wr_q;
                    rd_lo_d   = host_if.dbg_do[7:0];
                    tx_data_d = is_wr_q ? RSP_ACK : host_if.dbg_do[15:8];
                end else if (bus_expired_s) begin
                    state_d   = ST_RSP1;
                    has_lo_d  = 1'b0;
                    tx_data_d = RSP_NAK;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RSP1: begin
                if (host_if.tx_ready && has_lo_q) begin
                    state_d   = ST_RSP2;
                    tx_data_d = rd_lo_q;
                end else if (host_if.tx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP1;
                end
            end
            ST_RSP2: begin
                if (host_if.tx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs derived from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_wr_q    <= 1'b0;
            has_lo_q   <= 1'b0;
            rd_lo_q    <= 8'h00;
            dbg_a_q    <= 8'h00;
            dbg_di_q   <= 16'h0000;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            dbg_we_q   <= 1'b0;
            dbg_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            is_wr_q    <= is_wr_d;
            has_lo_q   <= has_lo_d;
            rd_lo_q    <= rd_lo_d;
            dbg_a_q    <= dbg_a_d;
            dbg_di_q   <= dbg_di_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= (state_d == ST_RSP1) || (state_d == ST_RSP2);
            dbg_we_q   <= (state_d == ST_BUS) && is_wr_d;
            dbg_rd_q   <= (state_d == ST_BUS) && !is_wr_d;
            busy_q     <= (state_d != ST_IDLE);
            overrun_q  <= host_if.rx_valid &&
                          ((state_q == ST_BUS) || (state_q == ST_RSP1) || (state_q == ST_RSP2));
        end
    end

    assign host_if.tx_data  = tx_data_q;
    assign host_if.tx_valid = tx_valid_q;
    assign host_if.dbg_a    = dbg_a_q;
    assign host_if.dbg_di   = dbg_di_q;
    assign host_if.dbg_we   = dbg_we_q;
    assign host_if.dbg_rd   = dbg_rd_q;
    assign host_if.busy     = busy_q;
    assign host_if.overrun  = overrun_q;

endmodule
